// File: rtl/pixel_sink.sv
// Serial pixel receiver: deserializes PX/PY/C words, maps Q10.6 coordinates to a
// linear framebuffer address, buffers pixels in a small FIFO and drains them under ready/valid.
module pixel_sink #(
  parameter int FRAC       = 6,
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PX,
  input  logic              PY,
  input  logic              C,
  input  logic              VALID,
  input  logic              DONE_IN,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic [15:0]       FB_DATA,
  output logic              FB_WE,
  input  logic              FB_READY,
  output logic              TRI_DONE,
  output logic [ADDR_W-1:0] PIX_CNT,
  output logic [15:0]       DROP_CNT,
  output logic              OVERFLOW,
  output logic              OVERRUN
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = ADDR_W + 16;
  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_SHIFT = 1'b1;
  localparam logic [15:0] WIDTH_W  = 16'(WIDTH);
  localparam logic [15:0] HEIGHT_W = 16'(HEIGHT);

  logic [0:0]        state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [15:0]       x_sr_q, x_sr_d;
  logic [15:0]       y_sr_q, y_sr_d;
  logic [15:0]       c_sr_q, c_sr_d;
  logic              word_ready_q, word_ready_d;
  logic              overrun_q, overrun_d;

  logic              conv_valid_q, conv_valid_d;
  logic [ADDR_W-1:0] conv_addr_q, conv_addr_d;
  logic [15:0]       conv_data_q, conv_data_d;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;

  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;
  logic              pending_q, pending_d;

  logic [15:0]       xi, yi;
  logic              oob;
  logic [ADDR_W-1:0] lin_addr;
  logic              empty, full, pop, push, drop_oob, drop_full;
  logic [1:0]        drop_inc;
  logic [16:0]       drop_sum;
  logic [ENT_W-1:0]  head;
  logic              tri_done;

  // A VALID that lands on the 16th bit does not restart capture; the word still completes.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    x_sr_d       = x_sr_q;
    y_sr_d       = y_sr_q;
    c_sr_d       = c_sr_q;
    word_ready_d = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (VALID) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
      end
      default: begin
        if (VALID && (bit_cnt_q != 4'd15)) begin
          bit_cnt_d = '0;
          overrun_d = 1'b1;
        end else begin
          x_sr_d    = {x_sr_q[14:0], PX};
          y_sr_d    = {y_sr_q[14:0], PY};
          c_sr_d    = {c_sr_q[14:0], C};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            word_ready_d = 1'b1;
            state_d      = ST_IDLE;
            if (VALID) overrun_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    xi       = 16'($signed(x_sr_q) >>> FRAC);
    yi       = 16'($signed(y_sr_q) >>> FRAC);
    oob      = x_sr_q[15] | y_sr_q[15] | (xi >= WIDTH_W) | (yi >= HEIGHT_W);
    lin_addr = ADDR_W'(yi) * ADDR_W'(WIDTH) + ADDR_W'(xi);
    conv_valid_d = word_ready_q && !oob;
    conv_addr_d  = word_ready_q ? lin_addr : conv_addr_q;
    conv_data_d  = word_ready_q ? c_sr_q : conv_data_q;
    drop_oob     = word_ready_q && oob;
  end

  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    pop       = !empty && FB_READY;
    push      = conv_valid_q && (!full || pop);
    drop_full = conv_valid_q && full && !pop;
    mem_d     = mem_q;
    if (push) mem_d[wr_ptr_q[PTR_W-1:0]] = {conv_addr_q, conv_data_q};
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    head      = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_comb begin
    drop_inc   = {1'b0, drop_oob} + {1'b0, drop_full};
    drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_inc);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    pix_cnt_d  = pix_cnt_q + ADDR_W'(pop);
    overflow_d = overflow_q | drop_full;
    tri_done   = pending_q && (state_q == ST_IDLE) && !word_ready_q && !conv_valid_q && empty;
    pending_d  = (pending_q && !tri_done) || DONE_IN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      x_sr_q       <= '0;
      y_sr_q       <= '0;
      c_sr_q       <= '0;
      word_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      conv_valid_q <= 1'b0;
      conv_addr_q  <= '0;
      conv_data_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pix_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      x_sr_q       <= x_sr_d;
      y_sr_q       <= y_sr_d;
      c_sr_q       <= c_sr_d;
      word_ready_q <= word_ready_d;
      overrun_q    <= overrun_d;
      conv_valid_q <= conv_valid_d;
      conv_addr_q  <= conv_addr_d;
      conv_data_q  <= conv_data_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pix_cnt_q    <= pix_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
      pending_q    <= pending_d;
    end
  end

  always_comb begin
    FB_WE    = !empty;
    FB_ADDR  = empty ? '0 : head[ENT_W-1:16];
    FB_DATA  = empty ? '0 : head[15:0];
    TRI_DONE = tri_done;
    PIX_CNT  = pix_cnt_q;
    DROP_CNT = drop_cnt_q;
    OVERFLOW = overflow_q;
    OVERRUN  = overrun_q;
  end

endmodule

// File: tb/tb_pixel_sink.sv
// Bench for pixel_sink: directed scenarios plus random frames, every cycle compared
// against a queue-based model that schedules each pixel by its VALID time.
module tb_pixel_sink;
  localparam int FRAC   = 6;
  localparam int WIDTH  = 320;
  localparam int HEIGHT = 240;
  localparam int ADDR_W = 17;
  localparam int DEPTH  = 4;

  logic              CLK;
  logic              RST = 1'b1;
  logic              PX = 1'b0, PY = 1'b0, C = 1'b0;
  logic              VALID = 1'b0, DONE_IN = 1'b0, FB_READY = 1'b0;
  logic [ADDR_W-1:0] FB_ADDR, PIX_CNT;
  logic [15:0]       FB_DATA, DROP_CNT;
  logic              FB_WE, TRI_DONE, OVERFLOW, OVERRUN;

  pixel_sink #(.FRAC(FRAC), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .PX(PX), .PY(PY), .C(C), .VALID(VALID), .DONE_IN(DONE_IN),
    .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_WE(FB_WE), .FB_READY(FB_READY),
    .TRI_DONE(TRI_DONE), .PIX_CNT(PIX_CNT), .DROP_CNT(DROP_CNT),
    .OVERFLOW(OVERFLOW), .OVERRUN(OVERRUN));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int failures = 0;
  int triCount = 0;
  bit cmpEn = 1'b0;
  int readyMode = 0;

  // Frame annotation read by the model when it sees VALID: 0 complete, 1 aborted, 2 ignored.
  int          vKind = 2;
  bit          vOverrun = 1'b0;
  logic [15:0] vX = '0, vY = '0, vC = '0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  typedef struct {
    int                due;
    bit                inb;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } sched_t;
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } pix_t;

  sched_t sched[$];
  pix_t   mFifo[$];
  int     cyc = 0;
  int     lv = -100;
  bit     lvInb = 1'b0;
  bit     mPending = 1'b0, expTri = 1'b0, mOverflow = 1'b0, mOverrun = 1'b0;
  longint mPix = 0;
  int     mDrop = 0;

  function automatic bit inBounds(input logic [15:0] x, input logic [15:0] y);
    int xi, yi;
    xi = int'(x) / 64;
    yi = int'(y) / 64;
    return (x < 16'h8000) && (y < 16'h8000) && (xi < WIDTH) && (yi < HEIGHT);
  endfunction

  function automatic logic [ADDR_W-1:0] linAddr(input logic [15:0] x, input logic [15:0] y);
    int a;
    a = (int'(y) / 64) * WIDTH + int'(x) / 64;
    return ADDR_W'(a);
  endfunction

  function automatic int satInc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Model: a pixel lands in the FIFO 18 cycles after its VALID (dropped at 17 if off-screen).
  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      sched.delete();
      mFifo.delete();
      mPending = 1'b0; expTri = 1'b0; mOverflow = 1'b0; mOverrun = 1'b0;
      mPix = 0; mDrop = 0; lv = cyc - 100; lvInb = 1'b0;
    end else begin
      bit inb;
      if (expTri) mPending = 1'b0;
      if (DONE_IN) mPending = 1'b1;
      if (mFifo.size() > 0 && FB_READY) begin
        mFifo.delete(0);
        mPix++;
      end
      while (sched.size() > 0 && sched[0].due <= cyc) begin
        if (!sched[0].inb) mDrop = satInc(mDrop);
        else if (mFifo.size() < DEPTH) mFifo.push_back('{sched[0].addr, sched[0].data});
        else begin
          mDrop = satInc(mDrop);
          mOverflow = 1'b1;
        end
        sched.delete(0);
      end
      if (VALID && vKind != 2) begin
        inb = inBounds(vX, vY);
        lv = cyc;
        lvInb = (vKind == 0) && inb;
        if (vKind == 0) sched.push_back('{cyc + (inb ? 18 : 17), inb, linAddr(vX, vY), vC});
      end
      if (VALID && vOverrun) mOverrun = 1'b1;
      expTri = mPending && mFifo.size() == 0 &&
               !(((cyc - lv) <= 16) || ((cyc - lv) == 17 && lvInb));
    end
  end

  always @(negedge CLK) begin
    if (cmpEn) begin
      checkOutput("fb_we", FB_WE, mFifo.size() > 0);
      if (mFifo.size() > 0) begin
        checkOutput("fb_addr", FB_ADDR, mFifo[0].addr);
        checkOutput("fb_data", FB_DATA, mFifo[0].data);
      end
      checkOutput("tri_done", TRI_DONE, expTri);
      checkOutput("pix_cnt", PIX_CNT, mPix % (64'd1 << ADDR_W));
      checkOutput("drop_cnt", DROP_CNT, mDrop);
      checkOutput("overflow", OVERFLOW, mOverflow);
      checkOutput("overrun", OVERRUN, mOverrun);
      if (TRI_DONE) triCount++;
    end
  end

  always @(negedge CLK) begin
    if (readyMode == 2) FB_READY = 1'($urandom_range(0, 1));
    else FB_READY = (readyMode == 1);
  end

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge CLK);
      VALID = 1'b0; DONE_IN = 1'b0; PX = 1'b0; PY = 1'b0; C = 1'b0;
    end
  endtask

  // One frame: VALID cycle then 16 MSB-first bits; optional VALID on bit 16 and DONE_IN on bit doneAt.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c,
                               input bit restart, input bit lastValid, input int doneAt);
    @(negedge CLK);
    vX = x; vY = y; vC = c; vKind = 0; vOverrun = restart;
    VALID = 1'b1; DONE_IN = 1'b0; PX = 1'b0; PY = 1'b0; C = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      VALID = (k == 16) && lastValid;
      vKind = 2;
      vOverrun = (k == 16) && lastValid;
      PX = x[16-k]; PY = y[16-k]; C = c[16-k];
      DONE_IN = (k == doneAt);
    end
  endtask

  task automatic sendAbort(input int nbits);
    @(negedge CLK);
    vKind = 1; vOverrun = 1'b0;
    VALID = 1'b1; DONE_IN = 1'b0;
    repeat (nbits) begin
      @(negedge CLK);
      VALID = 1'b0; vKind = 2;
      PX = 1'($urandom); PY = 1'($urandom); C = 1'($urandom);
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST = 1'b1; VALID = 1'b0; DONE_IN = 1'b0; PX = 1'b0; PY = 1'b0; C = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      idleCycles(1);
      if (!FB_WE) break;
    end
    checkOutput("drain_timeout", FB_WE, 0);
  endtask

  initial begin
    logic [15:0] sx [5];
    logic [15:0] sy [5];
    logic [15:0] rx, ry;
    sx = '{16'd192, 16'd832, 16'd1472, 16'd2112, 16'd2752};
    sy = '{16'd64, 16'd128, 16'd192, 16'd256, 16'd320};

    repeat (2) @(negedge CLK);
    cmpEn = 1'b1;
    checkOutput("rst_fb_we", FB_WE, 0);
    checkOutput("rst_pix_cnt", PIX_CNT, 0);
    checkOutput("rst_drop_cnt", DROP_CNT, 0);
    checkOutput("rst_tri_done", TRI_DONE, 0);
    RST = 1'b0;

    $display("[TB] single pixel");
    readyMode = 1;
    idleCycles(2);
    applyStimulus(16'd640, 16'd1280, 16'hF801, 1'b0, 1'b0, -1);
    idleCycles(2);
    checkOutput("s1_we_early", FB_WE, 0);
    idleCycles(1);
    checkOutput("s1_we", FB_WE, 1);
    checkOutput("s1_addr", FB_ADDR, 6410);
    checkOutput("s1_data", FB_DATA, 16'hF801);
    idleCycles(1);
    checkOutput("s1_pix_cnt", PIX_CNT, 1);

    $display("[TB] bounds");
    doReset();
    applyStimulus(16'd20480, 16'd0, 16'h1234, 1'b0, 1'b0, -1);
    applyStimulus(16'hFFC0, 16'd0, 16'h2345, 1'b0, 1'b0, -1);
    applyStimulus(16'd0, 16'd15360, 16'h3456, 1'b0, 1'b0, -1);
    idleCycles(20);
    checkOutput("s2_drop_cnt", DROP_CNT, 3);
    checkOutput("s2_overflow", OVERFLOW, 0);
    checkOutput("s2_pix_cnt", PIX_CNT, 0);

    $display("[TB] backpressure");
    readyMode = 0;
    doReset();
    idleCycles(2);
    for (int i = 0; i < 5; i++) applyStimulus(sx[i], sy[i], 16'(16'hA000 + i), 1'b0, 1'b0, -1);
    idleCycles(20);
    checkOutput("s3_overflow", OVERFLOW, 1);
    checkOutput("s3_drop_cnt", DROP_CNT, 1);
    checkOutput("s3_head_addr", FB_ADDR, 323);
    readyMode = 1;
    idleCycles(10);
    checkOutput("s3_pix_cnt", PIX_CNT, 4);

    $display("[TB] done ordering");
    doReset();
    idleCycles(2);
    triCount = 0;
    applyStimulus(16'd64, 16'd64, 16'h0F0F, 1'b0, 1'b0, -1);
    applyStimulus(16'd128, 16'd64, 16'hF0F0, 1'b0, 1'b0, 2);
    idleCycles(30);
    checkOutput("s4_tri_once", triCount, 1);
    triCount = 0;
    @(negedge CLK);
    DONE_IN = 1'b1;
    @(negedge CLK);
    DONE_IN = 1'b0;
    checkOutput("s4_empty_tri", TRI_DONE, 1);
    idleCycles(3);
    checkOutput("s4_empty_once", triCount, 1);

    $display("[TB] overrun");
    doReset();
    sendAbort(7);
    applyStimulus(16'd640, 16'd1280, 16'hF801, 1'b1, 1'b0, -1);
    idleCycles(3);
    checkOutput("s5_overrun", OVERRUN, 1);
    checkOutput("s5_addr", FB_ADDR, 6410);
    idleCycles(3);
    checkOutput("s5_pix_cnt", PIX_CNT, 1);

    doReset();
    applyStimulus(16'd320, 16'd448, 16'h5555, 1'b0, 1'b1, -1);
    idleCycles(3);
    checkOutput("s5b_overrun", OVERRUN, 1);
    checkOutput("s5b_addr", FB_ADDR, 2245);
    idleCycles(3);
    checkOutput("s5b_pix_cnt", PIX_CNT, 1);

    $display("[TB] reset mid-operation");
    readyMode = 0;
    doReset();
    idleCycles(2);
    applyStimulus(16'd640, 16'd640, 16'h1111, 1'b0, 1'b0, -1);
    applyStimulus(16'd1280, 16'd640, 16'h2222, 1'b0, 1'b0, -1);
    idleCycles(20);
    checkOutput("s6_queued", FB_WE, 1);
    sendAbort(9);
    doReset();
    checkOutput("s6_we", FB_WE, 0);
    checkOutput("s6_addr", FB_ADDR, 0);
    checkOutput("s6_data", FB_DATA, 0);
    checkOutput("s6_pix", PIX_CNT, 0);
    checkOutput("s6_drop", DROP_CNT, 0);
    readyMode = 1;
    idleCycles(2);
    applyStimulus(16'd64, 16'd0, 16'h7777, 1'b0, 1'b0, -1);
    idleCycles(22);
    checkOutput("s6_one_write", PIX_CNT, 1);

    $display("[TB] random traffic");
    readyMode = 2;
    doReset();
    for (int n = 0; n < 40; n++) begin
      idleCycles($urandom_range(0, 6));
      if ($urandom_range(0, 6) == 0) begin
        rx = 16'($urandom_range(0, 65535));
        ry = 16'($urandom_range(0, 65535));
      end else begin
        rx = 16'($urandom_range(0, WIDTH * 64 - 1));
        ry = 16'($urandom_range(0, HEIGHT * 64 - 1));
      end
      if ($urandom_range(0, 9) == 0) begin
        sendAbort($urandom_range(1, 14));
        applyStimulus(rx, ry, 16'($urandom), 1'b1, 1'b0, -1);
      end else begin
        applyStimulus(rx, ry, 16'($urandom), 1'b0, $urandom_range(0, 19) == 0,
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 16)) : -1);
      end
    end
    idleCycles(3);
    readyMode = 1;
    waitDrain(200);
    idleCycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_sink.md
Name: pixel_sink

Overview:
Receives the serial pixel stream produced by the rasterizer (PX, PY, C bit lanes framed by VALID) and deserializes each 16-bit word. It converts the Q10.6 pixel coordinates to a linear framebuffer address and buffers accepted pixels in a small FIFO. It drains them to the framebuffer write port under a ready/valid handshake. It also forwards the rasterizer's per-triangle DONE only once every pixel of that triangle has been written.

Parameters:
FRAC, 6, fractional bits of incoming coordinates
WIDTH, 320, screen width in pixels
HEIGHT, 240, screen height in pixels
ADDR_W, 17, framebuffer address width (must satisfy WIDTH*HEIGHT <= 2^ADDR_W)
FIFO_DEPTH, 4, pixel FIFO entries (power of two, >= 2)

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
PX  in  1  serial pixel x, Q10.6, MSB first
PY  in  1  serial pixel y, Q10.6, MSB first
C  in  1  serial color R5 G5 B5 A1, MSB first
VALID  in  1  one-cycle frame start for PX/PY/C
DONE_IN  in  1  one-cycle pulse, rasterizer finished current triangle
FB_ADDR  out  ADDR_W  write address = y*WIDTH + x
FB_DATA  out  16  write color
FB_WE  out  1  write request (valid)
FB_READY  in  1  framebuffer accepts write this cycle
TRI_DONE  out  1  one-cycle pulse, triangle fully written
PIX_CNT  out  ADDR_W  pixels written since reset (wraps)
DROP_CNT  out  16  pixels discarded since reset (saturates at 0xFFFF)
OVERFLOW  out  1  sticky: pixel dropped because FIFO full
OVERRUN  out  1  sticky: VALID received mid-word

Behaviour:
- Reset (RST=1 at a CLK edge): all outputs 0. FIFO is empty, deserializer is IDLE, and pending-done is cleared. Any partial word is discarded.
- Frame format: VALID is high for exactly one cycle t and carries no data. Bits 15..0 of all three lanes are sampled on cycles t+1..t+16, MSB first.
- Deserializer FSM states are IDLE and SHIFT, with a 4-bit bit counter.
  - IDLE -> SHIFT on VALID.
  - SHIFT shifts all three lanes in together. After the 16th bit it raises word_ready for one cycle and returns to IDLE.
  - VALID seen in SHIFT: the partial word is discarded, OVERRUN is set, and capture restarts (counter = 0, stay in SHIFT).
  - VALID on the same cycle as the 16th bit: that bit is treated as the 16th data bit and the word completes normally. VALID is ignored and OVERRUN is set.
- Convert stage (registered, the cycle after word_ready):
  - xi = x >>> FRAC and yi = y >>> FRAC, arithmetic shifts.
  - Out of bounds means x[15]=1, y[15]=1, xi >= WIDTH, or yi >= HEIGHT. Such a pixel is dropped and DROP_CNT increments.
  - Otherwise addr = yi*WIDTH + xi, truncated to ADDR_W bits, and {addr, color} is pushed to the FIFO.
- FIFO push when full: the pixel is dropped, DROP_CNT increments, and OVERFLOW is set.
  - A push and a pop in the same cycle on a full FIFO both succeed. This is not counted as an overflow.
- Output handshake:
  - FB_WE = FIFO not empty. FB_ADDR and FB_DATA are the FIFO head.
  - A write transfers when FB_WE && FB_READY. The head then pops and PIX_CNT increments.
  - While FB_WE && !FB_READY, FB_ADDR and FB_DATA hold stable.
- Latency, VALID at cycle t with FIFO empty: FB_WE is high from cycle t+18, with matching FB_ADDR and FB_DATA.
- Done tracking:
  - DONE_IN sets pending.
  - TRI_DONE pulses for one cycle when pending=1, the deserializer is IDLE, no word is in the convert stage, and the FIFO is empty. Pending then clears.
  - DONE_IN arriving while pending is already set keeps pending set (no double pulse).
  - A triangle with zero valid pixels pulses TRI_DONE 1 cycle after DONE_IN.
- DROP_CNT saturates at 0xFFFF. PIX_CNT wraps.

Test Plan:
1. Single pixel: VALID@t with PX=640 (10.0), PY=1280 (20.0), C=0xF801. Expect FB_WE=1 at t+18, FB_ADDR=6410, FB_DATA=0xF801. With FB_READY=1, PIX_CNT=1 after the transfer.
2. Bounds: send PX=20480 (xi=320), PY=0, then PX=0xFFC0 (negative), then PY=15360 (yi=240). Expect no FB_WE, DROP_CNT=3, OVERFLOW=0.
3. Backpressure: FB_READY=0, send 5 back-to-back in-bounds frames (17 cycles apart).
   - First 4 are queued, the 5th is dropped, OVERFLOW=1, DROP_CNT=1.
   - Raise FB_READY: 4 writes in order, addresses unchanged while stalled.
4. Done ordering: DONE_IN pulses 2 cycles after the last frame's VALID. TRI_DONE must pulse exactly once, on the cycle after the last pixel's FB_WE && FB_READY. DONE_IN with no pixels gives TRI_DONE 1 cycle later.
5. Overrun: second VALID at t+8 of a frame sets OVERRUN=1. The first word is never written; the second word is written correctly with the address per scenario 1.
6. Reset mid-operation: RST=1 at t+10 of a frame with 2 FIFO entries pending. Next cycle all outputs are 0, and a following clean frame produces exactly one write.
